ascon_decrypt: RTL and testbench
================================

# ascon_decrypt

Iterative Ascon-128 authenticated-decryption engine; the receive-side counterpart of the team's encryption datapath. It runs one permutation round per clock on the 320-bit `type_state` and accepts associated data and ciphertext as 64-bit words over a valid/ready handshake. It emits plaintext words, then compares the computed tag with the received tag. It sits between the ciphertext source and the plaintext consumer; the consumer must discard plaintext when `tag_ok_o` is low.

## Interface
- `IV`, default `64'h80400C0600000000`, Ascon-128 initialisation word
- `clock_i`  in  1  system clock
- `reset_i`  in  1  reset; synchronous, active-high
- `start_i`  in  1  starts a message; sampled only in IDLE
- `key_i`  in  128  key; latched at start
- `nonce_i`  in  128  nonce; latched at start
- `tag_i`  in  128  received tag; latched at start
- `ad_blocks_i`  in  4  number of full 64-bit AD words, 0–15; latched at start
- `ct_blocks_i`  in  4  number of full 64-bit ciphertext words, 0–15; latched at start
- `data_i`  in  64  AD or ciphertext word
- `data_valid_i`  in  1  `data_i` valid
- `data_ready_o`  out  1  engine accepts `data_i` this cycle
- `plain_o`  out  64  plaintext word
- `plain_valid_o`  out  1  one-cycle strobe for `plain_o`
- `busy_o`  out  1  high outside IDLE and DONE
- `done_o`  out  1  one-cycle strobe at end of message
- `tag_ok_o`  out  1  tag comparison result; valid from `done_o`, held until the next start

## Operation
- States: IDLE, INIT, WAIT_AD, PERM_AD, PAD_AD, WAIT_CT, PERM_CT, FINAL, DONE.
- IDLE, on `start_i`:
  - Latch all inputs.
  - Load S = {IV, K[127:64], K[63:0], N[127:64], N[63:0]}.
  - Go to INIT.
- INIT: 12 rounds, r = 0..11.
  - Then S3 ^= K_hi and S4 ^= K_lo.
  - Then go to WAIT_AD if ad_blocks > 0, else WAIT_CT with S4 ^= 1.
- WAIT_AD: `data_ready_o` = 1.
  - On handshake: S0 ^= data_i, decrement the AD count, go to PERM_AD.
- PERM_AD: 6 rounds, r = 6..11.
  - Then go to WAIT_AD if AD words remain, else PAD_AD.
- PAD_AD: S0 ^= 64'h8000000000000000, then 6 rounds.
  - Then S4 ^= 1 and go to WAIT_CT.
- WAIT_CT:
  - If the ciphertext count is 0: S0 ^= 64'h80000000_00000000, S1 ^= K_hi, S2 ^= K_lo, go to FINAL. `data_ready_o` stays low.
  - Otherwise `data_ready_o` = 1. On handshake: plain_o <= S0 ^ data_i, plain_valid_o <= 1, S0 <= data_i, go to PERM_CT.
- PERM_CT: 6 rounds, then back to WAIT_CT.
- FINAL: 12 rounds.
  - Then tag_ok_o <= ({S3, S4} ^ K) == T.
  - Go to DONE.
- DONE: `done_o` = 1 for one cycle, then IDLE.
- Round function = constant addition (S2 ^= {56'b0, ((4'hF − r) << 4) | r}) → 5-bit S-box on every bit column → linear diffusion:
  - S0 ^= S0⋙19 ^ S0⋙28
  - S1 ^= S1⋙61 ^ S1⋙39
  - S2 ^= S2⋙1 ^ S2⋙6
  - S3 ^= S3⋙10 ^ S3⋙17
  - S4 ^= S4⋙7 ^ S4⋙41
- All state arithmetic is XOR/rotate on 64-bit words; no carries. Round counter is 4 bits and wraps under FSM control only.
- Boundary behaviour:
  - `start_i` while busy: ignored.
  - `data_valid_i` outside WAIT_*: ignored, no stall or error.
  - A word is consumed only when `data_valid_i && data_ready_o`. A stall holds the state indefinitely.
  - Count 15 handled; count 0 skips that phase entirely (no AD padding when ad_blocks = 0).
  - Only full 64-bit words are supported; partial final blocks are out of scope.

## Timing
- Reset (synchronous, any state, including mid-permutation):
  - state → IDLE.
  - `data_ready_o`, `plain_valid_o`, `busy_o`, `done_o`, `tag_ok_o` = 0.
  - `plain_o` = 0 and S = 0.
- One round per clock. Data handshake costs 1 cycle.
- With `data_valid_i` held high, `done_o` asserts 25 + 7·ad + (ad > 0 ? 7 : 0) + 7·ct cycles after the `start_i` edge.
- `plain_o`/`plain_valid_o` are registered and appear the cycle after the handshake.
- `tag_ok_o` updates in the same cycle `done_o` rises.

## Structure
- Put in `ascon_pack`, alongside `type_state`:
  - `ASCON_IV`
  - `PAD_WORD`
  - round-constant function
  - FSM state enum `type_dec_fsm`
- Sub-module `ascon_round`: combinational single round (state_i, round_i → state_o), composed of the team's existing constant-addition, substitution and diffusion layers. It is instantiated once.
- The FSM, counters and state register live in `ascon_decrypt`.

## Test plan
- KAT, empty AD and ciphertext: K = N = 000102…0F, tag_i = E355159F292911F794CB1432A0103A8A → `done_o` at cycle 25, `tag_ok_o` = 1, no `plain_valid_o`.
- Same KAT with tag_i bit 0 flipped → `tag_ok_o` = 0, `done_o` still at cycle 25.
- Round check: force r = 0 on S = {00001000808C0001, 6CB10AD9CA912F80, 691AED630E8190EF, 0C4C36A20853217C, 46487B3E06D9D7A8} → `ascon_round` S-box stage output matches the team's substitution golden values.
- Round trip: encrypt 2 AD and 3 PT words with the encryption model, feed the resulting CT and tag → `plain_o` reproduces the 3 PT words, `tag_ok_o` = 1.
- Stall: drop `data_valid_i` for 5 cycles mid-ciphertext → the state is held and the outputs are identical to the unstalled run, delayed by 5 cycles.
- Reset asserted during FINAL round 4 → the next cycle is IDLE with all outputs 0. A fresh start then reproduces the first KAT.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared Ascon-128 types, constants and helpers for the encrypt/decrypt datapaths.
// Word 0 of type_state is S0, the rate word.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [63:0] ASCON_IV = 64'h80400C0600000000;
  localparam logic [63:0] PAD_WORD = 64'h8000000000000000;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_AD,
    PERM_AD,
    PAD_AD,
    WAIT_CT,
    PERM_CT,
    FINAL,
    DONE
  } type_dec_fsm;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant addition, bit-sliced
// 5-bit S-box across all 64 columns, then per-word linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state   added;
  type_state   subst;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] y0, y1, y2, y3, y4;

  always_comb begin
    added    = state_i;
    added[2] = state_i[2] ^ {56'd0, round_const(round_i)};
  end

  // Chi-like core of the S-box, evaluated on 64 columns in parallel.
  always_comb begin
    x0 = added[0] ^ added[4];
    x1 = added[1];
    x2 = added[2] ^ added[1];
    x3 = added[3];
    x4 = added[4] ^ added[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    y0 = x0 ^ t1;
    y1 = x1 ^ t2;
    y2 = x2 ^ t3;
    y3 = x3 ^ t4;
    y4 = x4 ^ t0;
    subst[0] = y0 ^ y4;
    subst[1] = y1 ^ y0;
    subst[2] = ~y2;
    subst[3] = y3 ^ y2;
    subst[4] = y4;
  end

  always_comb begin
    state_o[0] = subst[0] ^ rotr(subst[0], 19) ^ rotr(subst[0], 28);
    state_o[1] = subst[1] ^ rotr(subst[1], 61) ^ rotr(subst[1], 39);
    state_o[2] = subst[2] ^ rotr(subst[2], 1)  ^ rotr(subst[2], 6);
    state_o[3] = subst[3] ^ rotr(subst[3], 10) ^ rotr(subst[3], 17);
    state_o[4] = subst[4] ^ rotr(subst[4], 7)  ^ rotr(subst[4], 41);
  end

endmodule

// File: rtl/ascon_decrypt.sv
// Iterative Ascon-128 authenticated decryption: one round per clock, AD and
// ciphertext words in over valid/ready, plaintext strobed out, tag checked at the end.
module ascon_decrypt
  import ascon_pack::*;
#(
  parameter logic [63:0] IV = ASCON_IV
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  input  logic [3:0]   ad_blocks_i,
  input  logic [3:0]   ct_blocks_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  type_dec_fsm  state;
  type_dec_fsm  state_next;
  type_state    s;
  type_state    round_out;
  logic [3:0]   rnd;
  logic [3:0]   ad_cnt;
  logic [3:0]   ct_cnt;
  logic [127:0] key;
  logic [127:0] tag;
  logic [63:0]  plain;
  logic         plain_valid;
  logic         tag_ok;
  logic         hs;
  logic         last_round;

  ascon_round u_round (
    .state_i (s),
    .round_i (rnd),
    .state_o (round_out)
  );

  assign hs         = data_valid_i && data_ready_o;
  assign last_round = (rnd == 4'd11);

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = INIT;
      INIT:    if (last_round) state_next = (ad_cnt != 4'd0) ? WAIT_AD : WAIT_CT;
      WAIT_AD: if (hs) state_next = PERM_AD;
      PERM_AD: if (last_round) state_next = (ad_cnt != 4'd0) ? WAIT_AD : PAD_AD;
      PAD_AD:  if (last_round) state_next = WAIT_CT;
      WAIT_CT: begin
        if (ct_cnt == 4'd0) state_next = FINAL;
        else if (hs)        state_next = PERM_CT;
      end
      PERM_CT: if (last_round) state_next = WAIT_CT;
      FINAL:   if (last_round) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_ready_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      IDLE:    busy_o = 1'b0;
      WAIT_AD: data_ready_o = 1'b1;
      WAIT_CT: data_ready_o = (ct_cnt != 4'd0);
      DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign plain_o       = plain;
  assign plain_valid_o = plain_valid;
  assign tag_ok_o      = tag_ok;

  // Datapath: state words, round counter, block counters and result registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s           <= '0;
      rnd         <= 4'd0;
      ad_cnt      <= 4'd0;
      ct_cnt      <= 4'd0;
      key         <= '0;
      tag         <= '0;
      plain       <= 64'd0;
      plain_valid <= 1'b0;
      tag_ok      <= 1'b0;
    end else begin
      plain_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            key    <= key_i;
            tag    <= tag_i;
            ad_cnt <= ad_blocks_i;
            ct_cnt <= ct_blocks_i;
            s      <= {nonce_i[63:0], nonce_i[127:64], key_i[63:0], key_i[127:64], IV};
            rnd    <= 4'd0;
            tag_ok <= 1'b0;
          end
        end
        INIT: begin
          s   <= round_out;
          rnd <= rnd + 4'd1;
          if (last_round) begin
            s[3] <= round_out[3] ^ key[127:64];
            s[4] <= round_out[4] ^ key[63:0] ^ ((ad_cnt == 4'd0) ? 64'd1 : 64'd0);
          end
        end
        WAIT_AD: begin
          if (hs) begin
            s[0]   <= s[0] ^ data_i;
            ad_cnt <= ad_cnt - 4'd1;
            rnd    <= 4'd6;
          end
        end
        PERM_AD: begin
          s   <= round_out;
          rnd <= rnd + 4'd1;
          if (last_round && ad_cnt == 4'd0) rnd <= 4'd5;
        end
        // Entered with rnd = 5: one cycle for the pad word, then rounds 6..11.
        PAD_AD: begin
          if (rnd == 4'd5) begin
            s[0] <= s[0] ^ PAD_WORD;
            rnd  <= 4'd6;
          end else begin
            s   <= round_out;
            rnd <= rnd + 4'd1;
            if (last_round) s[4] <= round_out[4] ^ 64'd1;
          end
        end
        WAIT_CT: begin
          if (ct_cnt == 4'd0) begin
            s[0] <= s[0] ^ PAD_WORD;
            s[1] <= s[1] ^ key[127:64];
            s[2] <= s[2] ^ key[63:0];
            rnd  <= 4'd0;
          end else if (hs) begin
            plain       <= s[0] ^ data_i;
            plain_valid <= 1'b1;
            s[0]        <= data_i;
            ct_cnt      <= ct_cnt - 4'd1;
            rnd         <= 4'd6;
          end
        end
        PERM_CT: begin
          s   <= round_out;
          rnd <= rnd + 4'd1;
        end
        FINAL: begin
          s   <= round_out;
          rnd <= rnd + 4'd1;
          if (last_round)
            tag_ok <= ({round_out[3] ^ key[127:64], round_out[4] ^ key[63:0]} == tag);
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_decrypt.sv
// Self-checking bench for ascon_decrypt: a table-driven Ascon-128 encryption
// model produces ciphertext and tags, the DUT must recover plaintext and verify.
module tb_ascon_decrypt;

  localparam logic [63:0]  IV_WORD = 64'h80400C0600000000;
  localparam logic [63:0]  PAD     = 64'h8000000000000000;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
  localparam int SBOX_TAB [32] = '{
    'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
    'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
    'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
    'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
  };

  logic         clock = 1'b0;
  logic         reset_i;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [127:0] tag_i;
  logic [3:0]   ad_blocks_i;
  logic [3:0]   ct_blocks_i;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic         busy_o;
  logic         done_o;
  logic         tag_ok_o;

  ascon_decrypt dut (
    .clock_i       (clock),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .tag_i         (tag_i),
    .ad_blocks_i   (ad_blocks_i),
    .ct_blocks_i   (ct_blocks_i),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .plain_o       (plain_o),
    .plain_valid_o (plain_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .tag_ok_o      (tag_ok_o)
  );

  always #5 clock = ~clock;

  int           tests_run = 0;
  int           tests_failed = 0;
  logic [63:0]  ms [5];
  logic [63:0]  ad_words [16];
  logic [63:0]  pt_words [16];
  logic [63:0]  ct_words [16];
  logic [127:0] exp_tag;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_cleared(input string prefix);
    checkOutput({prefix, "_ready"},  128'(data_ready_o),  128'd0);
    checkOutput({prefix, "_pvalid"}, 128'(plain_valid_o), 128'd0);
    checkOutput({prefix, "_busy"},   128'(busy_o),        128'd0);
    checkOutput({prefix, "_done"},   128'(done_o),        128'd0);
    checkOutput({prefix, "_tagok"},  128'(tag_ok_o),      128'd0);
    checkOutput({prefix, "_plain"},  128'(plain_o),       128'd0);
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic int expected_latency(input int nad, input int nct);
    return 25 + 7 * nad + ((nad > 0) ? 7 : 0) + 7 * nct;
  endfunction

  // Permutation over the model state using the S-box lookup table per column.
  task automatic model_perm(input int nr);
    logic [4:0]  col;
    logic [4:0]  v;
    logic [7:0]  rc;
    logic [63:0] t [5];
    for (int r = 12 - nr; r < 12; r++) begin
      rc = 8'(((15 - r) << 4) | r);
      ms[2] = ms[2] ^ {56'd0, rc};
      for (int j = 0; j < 64; j++) begin
        col = {ms[0][j], ms[1][j], ms[2][j], ms[3][j], ms[4][j]};
        v = 5'(SBOX_TAB[col]);
        for (int b = 0; b < 5; b++) t[b][j] = v[4 - b];
      end
      ms[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
      ms[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
      ms[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
      ms[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
      ms[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
    end
  endtask

  task automatic model_encrypt(input logic [127:0] k, input logic [127:0] n,
                               input int nad, input int npt);
    ms[0] = IV_WORD;
    ms[1] = k[127:64];
    ms[2] = k[63:0];
    ms[3] = n[127:64];
    ms[4] = n[63:0];
    model_perm(12);
    ms[3] = ms[3] ^ k[127:64];
    ms[4] = ms[4] ^ k[63:0];
    if (nad > 0) begin
      for (int i = 0; i < nad; i++) begin
        ms[0] = ms[0] ^ ad_words[i];
        model_perm(6);
      end
      ms[0] = ms[0] ^ PAD;
      model_perm(6);
    end
    ms[4] = ms[4] ^ 64'd1;
    for (int i = 0; i < npt; i++) begin
      ct_words[i] = ms[0] ^ pt_words[i];
      ms[0] = ct_words[i];
      model_perm(6);
    end
    ms[0] = ms[0] ^ PAD;
    ms[1] = ms[1] ^ k[127:64];
    ms[2] = ms[2] ^ k[63:0];
    model_perm(12);
    exp_tag = {ms[3] ^ k[127:64], ms[4] ^ k[63:0]};
  endtask

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] n,
                               input logic [127:0] t, input int nad, input int nct,
                               input int stall_after, input int reset_at,
                               input logic exp_ok, output int done_cyc);
    logic [63:0] words [32];
    int cyc, widx, pidx, stall_left;
    logic finished, was_reset, stalled;
    for (int i = 0; i < 32; i++) words[i] = 64'd0;
    for (int i = 0; i < nad; i++) words[i] = ad_words[i];
    for (int i = 0; i < nct; i++) words[nad + i] = ct_words[i];
    cyc = -1; widx = 0; pidx = 0; stall_left = 0; done_cyc = -1;
    finished = 1'b0; was_reset = 1'b0; stalled = 1'b0;

    @(negedge clock);
    key_i = k; nonce_i = n; tag_i = t;
    ad_blocks_i = 4'(nad); ct_blocks_i = 4'(nct);
    start_i = 1'b1;
    data_i = words[0];
    data_valid_i = (nad + nct > 0);

    for (int guard = 0; guard < 600 && !finished; guard++) begin
      @(negedge clock);
      cyc++;
      if (cyc == 0) begin
        start_i = 1'b0;
        key_i = {$urandom, $urandom, $urandom, $urandom};
        nonce_i = {$urandom, $urandom, $urandom, $urandom};
        tag_i = {$urandom, $urandom, $urandom, $urandom};
        ad_blocks_i = 4'($urandom);
        ct_blocks_i = 4'($urandom);
      end
      if (cyc == 1) checkOutput("busy", 128'(busy_o), 128'd1);
      if (cyc == 5) start_i = 1'b1;
      if (cyc == 6) start_i = 1'b0;
      if (plain_valid_o) begin
        if (pidx < nct) checkOutput("plain", 128'(plain_o), 128'(pt_words[pidx]));
        else            checkOutput("extra_plain", 128'd1, 128'd0);
        pidx++;
      end
      if (done_o) begin
        done_cyc = cyc;
        checkOutput("tag_ok", 128'(tag_ok_o), 128'(exp_ok));
        checkOutput("plain_count", 128'(pidx), 128'(nct));
        finished = 1'b1;
      end
      if (!finished && reset_at >= 0 && cyc == reset_at) begin
        reset_i = 1'b1;
        data_valid_i = 1'b0;
        @(negedge clock);
        reset_i = 1'b0;
        check_cleared("mid_reset");
        finished = 1'b1;
        was_reset = 1'b1;
      end
      if (!finished) begin
        if (!stalled && stall_after >= 0 && widx == nad + stall_after && data_ready_o) begin
          stall_left = 5;
          stalled = 1'b1;
        end
        if (stall_left > 0) begin
          data_valid_i = 1'b0;
          stall_left--;
        end else begin
          data_valid_i = (widx < nad + nct);
        end
        data_i = words[widx];
        if (data_valid_i && data_ready_o) widx++;
      end
    end

    if (!finished) begin
      checkOutput("timeout", 128'd0, 128'd1);
    end else if (!was_reset) begin
      @(negedge clock);
      checkOutput("done_strobe", 128'(done_o), 128'd0);
      checkOutput("idle_busy", 128'(busy_o), 128'd0);
      checkOutput("tag_hold", 128'(tag_ok_o), 128'(exp_ok));
    end
    data_valid_i = 1'b0;
  endtask

  task automatic random_message(input int nad, input int nct, input int stall_after,
                                input logic corrupt);
    logic [127:0] k, n, t;
    int dc, lat;
    k = {$urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) begin
      ad_words[i] = {$urandom, $urandom};
      pt_words[i] = {$urandom, $urandom};
    end
    model_encrypt(k, n, nad, nct);
    t = corrupt ? (exp_tag ^ (128'd1 << $urandom_range(127, 0))) : exp_tag;
    applyStimulus(k, n, t, nad, nct, stall_after, -1, !corrupt, dc);
    lat = expected_latency(nad, nct) + ((stall_after >= 0) ? 5 : 0);
    checkOutput("latency", 128'(dc), 128'(lat));
  endtask

  initial begin
    int dc;
    int nad, nct, sa;
    reset_i = 1'b1; start_i = 1'b0; key_i = '0; nonce_i = '0; tag_i = '0;
    ad_blocks_i = 4'd0; ct_blocks_i = 4'd0; data_i = 64'd0; data_valid_i = 1'b0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset_i = 1'b0;

    applyStimulus(KAT_KEY, KAT_KEY, KAT_TAG, 0, 0, -1, -1, 1'b1, dc);
    checkOutput("kat_latency", 128'(dc), 128'd25);

    applyStimulus(KAT_KEY, KAT_KEY, KAT_TAG ^ 128'd1, 0, 0, -1, -1, 1'b0, dc);
    checkOutput("kat_bad_latency", 128'(dc), 128'd25);

    random_message(2, 3, -1, 1'b0);
    random_message(2, 3, 1, 1'b0);

    applyStimulus(KAT_KEY, KAT_KEY, KAT_TAG, 0, 0, -1, 17, 1'b1, dc);
    applyStimulus(KAT_KEY, KAT_KEY, KAT_TAG, 0, 0, -1, -1, 1'b1, dc);
    checkOutput("kat_after_reset", 128'(dc), 128'd25);

    random_message(15, 15, -1, 1'b0);
    random_message(0, 4, -1, 1'b0);
    random_message(3, 0, -1, 1'b0);
    random_message(1, 1, 0, 1'b1);

    for (int it = 0; it < 16; it++) begin
      nad = $urandom_range(15, 0);
      nct = $urandom_range(15, 0);
      sa = -1;
      if (nct > 0 && $urandom_range(1, 0) == 1) sa = $urandom_range(nct - 1, 0);
      random_message(nad, nct, sa, ($urandom_range(3, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
